// File: rtl/fifo_rd_arbiter.sv
// Read-port arbiter for the instruction prefetch FIFO: locked ownership, pop forwarding,
// registered data-valid strobes and a saturating per-instruction byte counter.
module fifo_rd_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] rd_en,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] rd_ack,
  output logic [NUM_REQ-1:0] data_valid,
  output logic               fifo_rd_en,
  input  logic               fifo_empty,
  input  logic               flush,
  input  logic               insn_start,
  output logic [LEN_W-1:0]   insn_length,
  output logic               rd_conflict
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OWNED = 1'b1;

  logic [0:0]         state_reg;
  logic [0:0]         state_next;
  logic [IDX_W-1:0]   owner_reg;
  logic [IDX_W-1:0]   owner_next;
  logic [NUM_REQ-1:0] data_valid_reg;
  logic [LEN_W-1:0]   insn_length_reg;
  logic [LEN_W-1:0]   insn_length_next;
  logic               rd_conflict_reg;

  logic [NUM_REQ-1:0] owner_onehot;
  logic [NUM_REQ-1:0] pick;
  logic               hold;
  logic               blocked;
  logic               pop;

  assign owner_onehot = NUM_REQ'(1) << owner_reg;
  // Two's-complement trick isolates the lowest set bit, i.e. the highest-priority requester.
  assign pick    = req & (~req + NUM_REQ'(1));
  assign hold    = (state_reg == OWNED) && ((req & owner_onehot) != '0);
  // Reset also gates the combinational outputs so every output reads zero while it is held.
  assign blocked = flush | reset;

  always_comb begin
    grant = '0;
    if (!blocked) begin
      grant = hold ? owner_onehot : pick;
    end
  end

  assign pop        = ((grant & rd_en) != '0) && !fifo_empty && !blocked;
  assign fifo_rd_en = pop;
  assign rd_ack     = pop ? (grant & rd_en) : '0;

  always_comb begin
    owner_next = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (grant[i]) begin
        owner_next = IDX_W'(i);
      end
    end
    state_next = (grant != '0) ? OWNED : IDLE;
  end

  always_comb begin
    insn_length_next = insn_length_reg;
    if (flush) begin
      insn_length_next = '0;
    end else if (insn_start) begin
      insn_length_next = pop ? LEN_W'(1) : '0;
    end else if (pop && (insn_length_reg != '1)) begin
      insn_length_next = insn_length_reg + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      owner_reg       <= '0;
      data_valid_reg  <= '0;
      insn_length_reg <= '0;
      rd_conflict_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      owner_reg       <= owner_next;
      // rd_ack is already zero under flush, so a strobe is only dropped when no pop happened.
      data_valid_reg  <= rd_ack;
      insn_length_reg <= insn_length_next;
      rd_conflict_reg <= ((rd_en & ~grant) != '0) && !flush;
    end
  end

  assign data_valid  = data_valid_reg;
  assign insn_length = insn_length_reg;
  assign rd_conflict = rd_conflict_reg;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed self-checking bench for fifo_rd_arbiter: arbitration, locking, empty stalls,
// conflicts, length saturation, flush and asynchronous reset.
module tb_fifo_rd_arbiter;

  logic       clk;
  logic       reset;
  logic [2:0] req;
  logic [2:0] rd_en;
  logic [2:0] grant;
  logic [2:0] rd_ack;
  logic [2:0] data_valid;
  logic       fifo_rd_en;
  logic       fifo_empty;
  logic       flush;
  logic       insn_start;
  logic [3:0] insn_length;
  logic       rd_conflict;

  int checks   = 0;
  int failures = 0;

  fifo_rd_arbiter #(.NUM_REQ(3), .LEN_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .rd_en      (rd_en),
    .grant      (grant),
    .rd_ack     (rd_ack),
    .data_valid (data_valid),
    .fifo_rd_en (fifo_rd_en),
    .fifo_empty (fifo_empty),
    .flush      (flush),
    .insn_start (insn_start),
    .insn_length(insn_length),
    .rd_conflict(rd_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns after the inputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; rd_en = '0; fifo_empty = 1'b1;
    flush = 1'b0; insn_start = 1'b0;
    tick(); tick();
    #1;
    checks++; if (grant !== 3'b000) begin failures++; $display("FAIL reset_grant got=%b exp=000", grant); end
    checks++; if (data_valid !== 3'b000) begin failures++; $display("FAIL reset_data_valid got=%b exp=000", data_valid); end
    checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_fifo_rd_en got=%b exp=0", fifo_rd_en); end
    checks++; if (insn_length !== 4'd0) begin failures++; $display("FAIL reset_insn_length got=%0d exp=0", insn_length); end
    checks++; if (rd_conflict !== 1'b0) begin failures++; $display("FAIL reset_rd_conflict got=%b exp=0", rd_conflict); end
    tick();
    reset = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_basic();
    req = 3'b110; rd_en = 3'b010; fifo_empty = 1'b0; insn_start = 1'b1;
    #1;
    checks++; if (grant !== 3'b010) begin failures++; $display("FAIL basic_grant got=%b exp=010", grant); end
    checks++; if (fifo_rd_en !== 1'b1) begin failures++; $display("FAIL basic_fifo_rd_en got=%b exp=1", fifo_rd_en); end
    checks++; if (rd_ack !== 3'b010) begin failures++; $display("FAIL basic_rd_ack got=%b exp=010", rd_ack); end
    tick();
    rd_en = '0; insn_start = 1'b0;
    #1;
    checks++; if (data_valid !== 3'b010) begin failures++; $display("FAIL basic_data_valid got=%b exp=010", data_valid); end
    checks++; if (insn_length !== 4'd1) begin failures++; $display("FAIL basic_insn_length got=%0d exp=1", insn_length); end
    req = '0;
    tick();
    checks++; if (grant !== 3'b000) begin failures++; $display("FAIL basic_release_grant got=%b exp=000", grant); end
    checks++; if (data_valid !== 3'b000) begin failures++; $display("FAIL basic_dv_clear got=%b exp=000", data_valid); end
    $display("test_basic done");
  endtask

  task automatic test_lock();
    rd_en = 3'b010; insn_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req = (i >= 1) ? 3'b011 : 3'b010;
      if (i > 0) insn_start = 1'b0;
      #1;
      checks++; if (grant !== 3'b010) begin failures++; $display("FAIL lock_grant_%0d got=%b exp=010", i, grant); end
      checks++; if (fifo_rd_en !== 1'b1) begin failures++; $display("FAIL lock_pop_%0d got=%b exp=1", i, fifo_rd_en); end
      tick();
    end
    insn_start = 1'b0; rd_en = '0;
    #1;
    checks++; if (insn_length !== 4'd3) begin failures++; $display("FAIL lock_insn_length got=%0d exp=3", insn_length); end
    checks++; if (data_valid !== 3'b010) begin failures++; $display("FAIL lock_data_valid got=%b exp=010", data_valid); end
    req = 3'b001;
    #1;
    checks++; if (grant !== 3'b001) begin failures++; $display("FAIL lock_handover got=%b exp=001", grant); end
    tick();
    $display("test_lock done");
  endtask

  task automatic test_empty();
    rd_en = 3'b001; fifo_empty = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL empty_pop_%0d got=%b exp=0", i, fifo_rd_en); end
      checks++; if (rd_ack !== 3'b000) begin failures++; $display("FAIL empty_ack_%0d got=%b exp=000", i, rd_ack); end
      tick();
      checks++; if (data_valid !== 3'b000) begin failures++; $display("FAIL empty_dv_%0d got=%b exp=000", i, data_valid); end
    end
    fifo_empty = 1'b0;
    #1;
    checks++; if (fifo_rd_en !== 1'b1) begin failures++; $display("FAIL empty_retry_pop got=%b exp=1", fifo_rd_en); end
    tick();
    rd_en = '0;
    #1;
    checks++; if (data_valid !== 3'b001) begin failures++; $display("FAIL empty_retry_dv got=%b exp=001", data_valid); end
    checks++; if (insn_length !== 4'd4) begin failures++; $display("FAIL empty_insn_length got=%0d exp=4", insn_length); end
    tick();
    checks++; if (data_valid !== 3'b000) begin failures++; $display("FAIL empty_single_dv got=%b exp=000", data_valid); end
    $display("test_empty done");
  endtask

  task automatic test_conflict();
    req = 3'b001; rd_en = 3'b100;
    #1;
    checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL conflict_pop got=%b exp=0", fifo_rd_en); end
    checks++; if (rd_ack !== 3'b000) begin failures++; $display("FAIL conflict_ack got=%b exp=000", rd_ack); end
    tick();
    rd_en = '0;
    #1;
    checks++; if (rd_conflict !== 1'b1) begin failures++; $display("FAIL conflict_flag got=%b exp=1", rd_conflict); end
    tick();
    checks++; if (rd_conflict !== 1'b0) begin failures++; $display("FAIL conflict_clear got=%b exp=0", rd_conflict); end
    $display("test_conflict done");
  endtask

  task automatic test_saturate();
    req = 3'b001; rd_en = 3'b001; insn_start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      insn_start = 1'b0;
    end
    #1;
    checks++; if (insn_length !== 4'd15) begin failures++; $display("FAIL sat_insn_length got=%0d exp=15", insn_length); end
    insn_start = 1'b1;
    tick();
    checks++; if (insn_length !== 4'd1) begin failures++; $display("FAIL sat_restart_pop got=%0d exp=1", insn_length); end
    rd_en = '0;
    tick();
    insn_start = 1'b0;
    #1;
    checks++; if (insn_length !== 4'd0) begin failures++; $display("FAIL sat_restart_nopop got=%0d exp=0", insn_length); end
    $display("test_saturate done");
  endtask

  task automatic test_back_to_back();
    req = 3'b010; rd_en = 3'b010;
    tick();
    req = 3'b001; rd_en = 3'b001;
    #1;
    checks++; if (grant !== 3'b001) begin failures++; $display("FAIL b2b_grant got=%b exp=001", grant); end
    checks++; if (rd_ack !== 3'b001) begin failures++; $display("FAIL b2b_ack got=%b exp=001", rd_ack); end
    checks++; if (data_valid !== 3'b010) begin failures++; $display("FAIL b2b_dv_owed got=%b exp=010", data_valid); end
    tick();
    rd_en = '0;
    #1;
    checks++; if (data_valid !== 3'b001) begin failures++; $display("FAIL b2b_dv_next got=%b exp=001", data_valid); end
    checks++; if (insn_length !== 4'd2) begin failures++; $display("FAIL b2b_insn_length got=%0d exp=2", insn_length); end
    req = '0;
    tick();
    $display("test_back_to_back done");
  endtask

  task automatic test_flush();
    req = 3'b010; rd_en = 3'b010;
    tick();
    req = 3'b011; flush = 1'b1; insn_start = 1'b1;
    #1;
    checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL flush_pop got=%b exp=0", fifo_rd_en); end
    checks++; if (grant !== 3'b000) begin failures++; $display("FAIL flush_grant got=%b exp=000", grant); end
    tick();
    flush = 1'b0; insn_start = 1'b0; rd_en = '0;
    #1;
    checks++; if (data_valid !== 3'b000) begin failures++; $display("FAIL flush_dv got=%b exp=000", data_valid); end
    checks++; if (insn_length !== 4'd0) begin failures++; $display("FAIL flush_insn_length got=%0d exp=0", insn_length); end
    checks++; if (grant !== 3'b001) begin failures++; $display("FAIL flush_idle_grant got=%b exp=001", grant); end
    req = '0;
    tick();
    $display("test_flush done");
  endtask

  task automatic test_async_reset();
    req = 3'b001; rd_en = 3'b001;
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (grant !== 3'b000) begin failures++; $display("FAIL areset_grant got=%b exp=000", grant); end
    checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL areset_pop got=%b exp=0", fifo_rd_en); end
    checks++; if (rd_ack !== 3'b000) begin failures++; $display("FAIL areset_ack got=%b exp=000", rd_ack); end
    checks++; if (data_valid !== 3'b000) begin failures++; $display("FAIL areset_dv got=%b exp=000", data_valid); end
    checks++; if (insn_length !== 4'd0) begin failures++; $display("FAIL areset_insn_length got=%0d exp=0", insn_length); end
    req = '0; rd_en = '0;
    tick();
    reset = 1'b0;
    tick();
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lock();
    test_empty();
    test_conflict();
    test_saturate();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
